// File: rtl/router_port.sv
// router_port: router-side byte-link endpoint with RX deserialiser and TX serialiser FIFOs
module router_port #(
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        put_outbound,
  input  logic [7:0]  payload_outbound,
  output logic        free_outbound,
  output logic        put_inbound,
  output logic [7:0]  payload_inbound,
  input  logic        free_inbound,
  output logic [31:0] rx_pkt,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [31:0] tx_pkt,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        proto_err
);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam logic [RAW:0] RX_FULL = (RAW + 1)'(RX_DEPTH);
  localparam logic [TAW:0] TX_FULL = (TAW + 1)'(TX_DEPTH);
  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_t;
  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;
  logic [31:0] rx_mem [RX_DEPTH];
  logic [31:0] tx_mem [TX_DEPTH];
  logic [RAW-1:0] rx_wr, rx_rd;
  logic [TAW-1:0] tx_wr, tx_rd;
  logic [RAW:0] rx_count;
  logic [TAW:0] tx_count;
  logic [23:0] rx_shift, tx_shift;
  logic [1:0] rx_cnt, tx_cnt;
  logic put_q;
  logic [7:0] byte_q;
  logic rx_push, rx_pop, tx_push, tx_pop, err_set;
  assign free_outbound = (rx_state == RX_IDLE) & (rx_count < RX_FULL) & ~rst;
  assign rx_valid = (rx_count != '0) & ~rst;
  assign rx_pkt = rx_mem[rx_rd];
  assign rx_pop = rx_valid & rx_ready;
  assign tx_ready = (tx_count < TX_FULL) & ~rst;
  assign tx_push = tx_valid & tx_ready;
  assign put_inbound = put_q & ~rst;
  assign payload_inbound = rst ? 8'h00 : byte_q;
  // next-state decode for both link directions
  always_comb begin
    rx_next = rx_state;
    rx_push = 1'b0;
    err_set = 1'b0;
    tx_next = tx_state;
    tx_pop = 1'b0;
    if (rx_state == RX_IDLE) begin
      rx_next = (put_outbound & free_outbound) ? RX_RECV : RX_IDLE;
      err_set = put_outbound & ~free_outbound;
    end else begin
      rx_push = put_outbound & (rx_cnt == 2'd3);
      err_set = ~put_outbound;
      rx_next = (put_outbound & (rx_cnt != 2'd3)) ? RX_RECV : RX_IDLE;
    end
    if (tx_state == TX_IDLE) begin
      tx_pop = (tx_count != '0) & free_inbound;
      tx_next = tx_pop ? TX_SEND : TX_IDLE;
    end else begin
      tx_next = tx_state == TX_GAP ? TX_IDLE : (tx_cnt == 2'd3 ? TX_GAP : TX_SEND);
    end
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      tx_state <= TX_IDLE;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end
  end
  // RX byte assembly, RX FIFO and sticky protocol error
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr <= '0;
      rx_rd <= '0;
      rx_count <= '0;
      rx_cnt <= 2'd0;
      rx_shift <= '0;
      proto_err <= 1'b0;
    end else begin
      if (put_outbound & (rx_state == RX_RECV | free_outbound)) begin
        rx_shift <= rx_state == RX_IDLE ? {16'h0, payload_outbound} : {rx_shift[15:0], payload_outbound};
        rx_cnt <= rx_state == RX_IDLE ? 2'd1 : rx_cnt + 2'd1;
      end
      if (rx_push) begin
        rx_mem[rx_wr] <= {rx_shift, payload_outbound};
        rx_wr <= rx_wr + 1'b1;
      end
      if (rx_pop) rx_rd <= rx_rd + 1'b1;
      if (rx_push & ~rx_pop) rx_count <= rx_count + 1'b1;
      else if (~rx_push & rx_pop) rx_count <= rx_count - 1'b1;
      if (err_set) proto_err <= 1'b1;
    end
  end
  // TX FIFO and registered byte serialiser; bytes leave one cycle after their decision edge
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr <= '0;
      tx_rd <= '0;
      tx_count <= '0;
      tx_cnt <= 2'd0;
      tx_shift <= '0;
      put_q <= 1'b0;
      byte_q <= 8'h00;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr] <= tx_pkt;
        tx_wr <= tx_wr + 1'b1;
      end
      if (tx_pop) begin
        tx_rd <= tx_rd + 1'b1;
        put_q <= 1'b1;
        byte_q <= tx_mem[tx_rd][31:24];
        tx_shift <= tx_mem[tx_rd][23:0];
        tx_cnt <= 2'd1;
      end else if (tx_state == TX_SEND) begin
        byte_q <= tx_shift[23:16];
        tx_shift <= {tx_shift[15:0], 8'h00};
        tx_cnt <= tx_cnt + 2'd1;
      end else begin
        put_q <= 1'b0;
        byte_q <= 8'h00;
      end
      if (tx_push & ~tx_pop) tx_count <= tx_count + 1'b1;
      else if (~tx_push & tx_pop) tx_count <= tx_count - 1'b1;
    end
  end
endmodule

// File: tb/tb_router_port.sv
// tb_router_port: randomized self-checking bench for router_port against queue-based packet models
module tb_router_port;
  logic clk, rst, put_outbound, free_outbound, put_inbound, free_inbound;
  logic rx_valid, rx_ready, tx_valid, tx_ready, proto_err;
  logic [7:0] payload_outbound, payload_inbound;
  logic [31:0] rx_pkt, tx_pkt;
  int checks = 0, errors = 0;
  logic [31:0] rxq[$];
  logic [31:0] txq[$];
  logic [31:0] got[$];
  int starts[$];
  int cyc = 0, cur_n = 0, bad_run = 0, bad_idle = 0;
  logic [31:0] cur;

  router_port #(.RX_DEPTH(4), .TX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .put_outbound(put_outbound), .payload_outbound(payload_outbound),
    .free_outbound(free_outbound), .put_inbound(put_inbound), .payload_inbound(payload_inbound),
    .free_inbound(free_inbound), .rx_pkt(rx_pkt), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_pkt(tx_pkt), .tx_valid(tx_valid), .tx_ready(tx_ready), .proto_err(proto_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // node-side receiver: reassemble 4-byte bursts, note run-length and idle-byte violations
  always @(negedge clk) begin
    cyc++;
    if (rst) cur_n = 0;
    else if (put_inbound) begin
      if (cur_n == 0) starts.push_back(cyc);
      cur = {cur[23:0], payload_inbound};
      cur_n++;
      if (cur_n == 4) begin
        got.push_back(cur);
        cur_n = 0;
      end
    end else begin
      if (cur_n != 0) bad_run++;
      cur_n = 0;
      if (payload_inbound !== 8'h00) bad_idle++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [31:0] p);
    for (int n = 0; n < 50 && !free_outbound; n++) tick;
    if (!free_outbound) begin
      checks++;
      errors++;
      $display("FAIL send_wait: free_outbound got 0 required 1");
    end
    for (int i = 0; i < 4; i++) begin
      put_outbound = 1;
      payload_outbound = p[31-8*i -: 8];
      tick;
    end
    put_outbound = 0;
    payload_outbound = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    tick;
    tick;
    checks++; if (free_outbound !== 1'b0) begin errors++; $display("FAIL rst_free_outbound: got %b required 0", free_outbound); end
    checks++; if (put_inbound !== 1'b0) begin errors++; $display("FAIL rst_put_inbound: got %b required 0", put_inbound); end
    checks++; if (payload_inbound !== 8'h00) begin errors++; $display("FAIL rst_payload_inbound: got %h required 00", payload_inbound); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b required 0", rx_valid); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rst_tx_ready: got %b required 0", tx_ready); end
    rst = 0;
    #1;
    checks++; if (free_outbound !== 1'b1) begin errors++; $display("FAIL post_rst_free: got %b required 1", free_outbound); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL post_rst_tx_ready: got %b required 1", tx_ready); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL post_rst_proto_err: got %b required 0", proto_err); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL post_rst_rx_valid: got %b required 0", rx_valid); end
  endtask

  task automatic test_rx_basic;
    rx_ready = 0;
    send_pkt(32'hDEADBEEF);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rx_basic_valid: got %b required 1", rx_valid); end
    checks++; if (rx_pkt !== 32'hDEADBEEF) begin errors++; $display("FAIL rx_basic_pkt: got %h required deadbeef", rx_pkt); end
    checks++; if (free_outbound !== 1'b1) begin errors++; $display("FAIL rx_basic_free: got %b required 1", free_outbound); end
    rx_ready = 1;
    tick;
    rx_ready = 0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_basic_drain: got %b required 0", rx_valid); end
  endtask

  task automatic test_rx_random;
    logic [31:0] p;
    int n;
    rx_ready = 0;
    repeat (4) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        p = $urandom;
        send_pkt(p);
        rxq.push_back(p);
        checks++; if (free_outbound !== (rxq.size() < 4)) begin errors++; $display("FAIL rx_rand_free: got %b required %b", free_outbound, rxq.size() < 4); end
      end
      while (rxq.size() > 0) begin
        repeat ($urandom_range(0, 2)) tick;
        checks++; if (rx_valid !== 1'b1 || rx_pkt !== rxq[0]) begin errors++; $display("FAIL rx_rand_pkt: got %b/%h required 1/%h", rx_valid, rx_pkt, rxq[0]); end
        rx_ready = 1;
        tick;
        rx_ready = 0;
        void'(rxq.pop_front());
      end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_rand_empty: got %b required 0", rx_valid); end
    end
  endtask

  task automatic test_rx_full;
    logic [31:0] p;
    rx_ready = 0;
    for (int i = 0; i < 4; i++) begin
      p = $urandom;
      send_pkt(p);
      rxq.push_back(p);
    end
    checks++; if (free_outbound !== 1'b0) begin errors++; $display("FAIL rx_full_free: got %b required 0", free_outbound); end
    tick;
    checks++; if (free_outbound !== 1'b0) begin errors++; $display("FAIL rx_full_hold: got %b required 0", free_outbound); end
    rx_ready = 1;
    tick;
    rx_ready = 0;
    void'(rxq.pop_front());
    checks++; if (free_outbound !== 1'b1) begin errors++; $display("FAIL rx_full_reopen: got %b required 1", free_outbound); end
    while (rxq.size() > 0) begin
      checks++; if (rx_valid !== 1'b1 || rx_pkt !== rxq[0]) begin errors++; $display("FAIL rx_full_pkt: got %b/%h required 1/%h", rx_valid, rx_pkt, rxq[0]); end
      rx_ready = 1;
      tick;
      rx_ready = 0;
      void'(rxq.pop_front());
    end
  endtask

  task automatic test_tx_basic;
    int highs = 0;
    got.delete();
    starts.delete();
    free_inbound = 0;
    tx_pkt = 32'h01020304;
    tx_valid = 1;
    tick;
    tx_valid = 0;
    repeat (5) begin
      tick;
      if (put_inbound) highs++;
    end
    checks++; if (highs != 0) begin errors++; $display("FAIL tx_hold_free: got %0d put cycles required 0", highs); end
    free_inbound = 1;
    for (int n = 0; n < 20 && got.size() < 1; n++) tick;
    checks++; if (got.size() != 1 || got[0] !== 32'h01020304) begin errors++; $display("FAIL tx_basic_pkt: got %0d pkts first %h required 1 pkt 01020304", got.size(), got.size() ? got[0] : 32'h0); end
    checks++; if (put_inbound !== 1'b0) begin errors++; $display("FAIL tx_basic_gap: got %b required 0", put_inbound); end
    checks++; if (bad_run != 0 || bad_idle != 0) begin errors++; $display("FAIL tx_basic_framing: got runs %0d idle %0d required 0 0", bad_run, bad_idle); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] p;
    got.delete();
    starts.delete();
    txq.delete();
    free_inbound = 1;
    for (int k = 0; k < 5; k++) begin
      p = $urandom;
      tx_pkt = p;
      tx_valid = 1;
      for (int n = 0; n < 40 && !tx_ready; n++) tick;
      txq.push_back(p);
      tick;
    end
    tx_valid = 0;
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: tx_ready got %b required 0", tx_ready); end
    for (int n = 0; n < 80 && got.size() < 5; n++) tick;
    checks++; if (got.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d required 5", got.size()); end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      checks++; if (got[k] !== txq[k]) begin errors++; $display("FAIL b2b_pkt%0d: got %h required %h", k, got[k], txq[k]); end
    end
    for (int k = 1; k < 5 && k < starts.size(); k++) begin
      checks++; if (starts[k] - starts[k-1] != 5) begin errors++; $display("FAIL b2b_spacing%0d: got %0d required 5", k, starts[k] - starts[k-1]); end
    end
  endtask

  task automatic test_tx_random;
    got.delete();
    starts.delete();
    txq.delete();
    for (int c = 0; c < 200; c++) begin
      free_inbound = 1'($urandom_range(0, 1));
      tx_valid = 1'($urandom_range(0, 1));
      tx_pkt = $urandom;
      if (tx_valid && tx_ready) txq.push_back(tx_pkt);
      tick;
    end
    tx_valid = 0;
    free_inbound = 1;
    for (int n = 0; n < 300 && got.size() < txq.size(); n++) tick;
    repeat (8) tick;
    checks++; if (got.size() != txq.size()) begin errors++; $display("FAIL tx_rand_count: got %0d required %0d", got.size(), txq.size()); end
    for (int k = 0; k < txq.size() && k < got.size(); k++) begin
      checks++; if (got[k] !== txq[k]) begin errors++; $display("FAIL tx_rand_pkt%0d: got %h required %h", k, got[k], txq[k]); end
    end
    checks++; if (bad_run != 0 || bad_idle != 0) begin errors++; $display("FAIL tx_rand_framing: got runs %0d idle %0d required 0 0", bad_run, bad_idle); end
  endtask

  task automatic test_proto_err;
    logic [31:0] p;
    rx_ready = 0;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_before: got %b required 0", proto_err); end
    for (int i = 0; i < 2; i++) begin
      put_outbound = 1;
      payload_outbound = 8'($urandom);
      tick;
    end
    put_outbound = 0;
    tick;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_trunc: got %b required 1", proto_err); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL perr_no_push: got %b required 0", rx_valid); end
    p = $urandom;
    send_pkt(p);
    checks++; if (rx_valid !== 1'b1 || rx_pkt !== p) begin errors++; $display("FAIL perr_recover: got %b/%h required 1/%h", rx_valid, rx_pkt, p); end
    rx_ready = 1;
    tick;
    rx_ready = 0;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b required 1", proto_err); end
  endtask

  task automatic test_reset_mid;
    int highs = 0;
    rx_ready = 0;
    send_pkt($urandom);
    free_inbound = 1;
    for (int k = 0; k < 2; k++) begin
      tx_pkt = $urandom;
      tx_valid = 1;
      tick;
    end
    tx_valid = 0;
    put_outbound = 1;
    payload_outbound = 8'hA1;
    tick;
    payload_outbound = 8'hA2;
    tick;
    payload_outbound = 8'hA3;
    checks++; if (put_inbound !== 1'b1) begin errors++; $display("FAIL rmid_inflight: got %b required 1", put_inbound); end
    rst = 1;
    #1;
    checks++; if (put_inbound !== 1'b0) begin errors++; $display("FAIL rmid_put_during: got %b required 0", put_inbound); end
    tick;
    rst = 0;
    put_outbound = 0;
    payload_outbound = 0;
    #1;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_rx_empty: got %b required 0", rx_valid); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rmid_proto_err: got %b required 0", proto_err); end
    checks++; if (free_outbound !== 1'b1) begin errors++; $display("FAIL rmid_free: got %b required 1", free_outbound); end
    repeat (12) begin
      tick;
      if (put_inbound) highs++;
    end
    checks++; if (highs != 0) begin errors++; $display("FAIL rmid_tx_empty: got %0d put cycles required 0", highs); end
  endtask

  task automatic test_overrun;
    logic [31:0] p;
    rx_ready = 0;
    for (int i = 0; i < 4; i++) begin
      p = $urandom;
      send_pkt(p);
      rxq.push_back(p);
    end
    checks++; if (free_outbound !== 1'b0) begin errors++; $display("FAIL ovr_free: got %b required 0", free_outbound); end
    put_outbound = 1;
    payload_outbound = 8'h5A;
    tick;
    put_outbound = 0;
    payload_outbound = 0;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL ovr_proto_err: got %b required 1", proto_err); end
    while (rxq.size() > 0) begin
      checks++; if (rx_valid !== 1'b1 || rx_pkt !== rxq[0]) begin errors++; $display("FAIL ovr_pkt: got %b/%h required 1/%h", rx_valid, rx_pkt, rxq[0]); end
      rx_ready = 1;
      tick;
      rx_ready = 0;
      void'(rxq.pop_front());
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drained: got %b required 0", rx_valid); end
  endtask

  initial begin
    rst = 1;
    put_outbound = 0;
    payload_outbound = 0;
    free_inbound = 0;
    rx_ready = 0;
    tx_pkt = 0;
    tx_valid = 0;
    test_reset;
    test_rx_basic;
    test_rx_random;
    test_rx_full;
    test_tx_basic;
    test_back_to_back;
    test_tx_random;
    test_proto_err;
    test_reset_mid;
    test_overrun;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
